// File: rtl/sram_like_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter_pkg
// Brief    : State, owner and transfer-size encodings shared by the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sram_like_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter_if
// Brief    : sram-like request/response bundle; master issues, slave answers.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_like_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface
`default_nettype wire

// File: rtl/sram_like_req_mux.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_req_mux
// Brief    : Owner-select of the request fields and steering of ok/rdata back.
// Revision : 1.0 - initial release
// ============================================================================
module sram_like_req_mux
  import sram_like_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              owner,
  input  logic              addr_phase,
  input  logic              data_phase,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata
);

  logic w_sel_data;
  logic w_addr_ack;
  logic w_data_ack;

  assign w_sel_data = (owner == OWN_DATA);

  assign bus_wr    = w_sel_data ? data_wr    : inst_wr;
  assign bus_size  = w_sel_data ? data_size  : inst_size;
  assign bus_addr  = w_sel_data ? data_addr  : inst_addr;
  assign bus_wdata = w_sel_data ? data_wdata : inst_wdata;

  // A data_ok coinciding with addr_ok completes the transfer without a DATA visit.
  assign w_addr_ack = addr_phase & bus_addr_ok;
  assign w_data_ack = (w_addr_ack & bus_data_ok) | (data_phase & bus_data_ok);

  assign inst_addr_ok = w_addr_ack & ~w_sel_data;
  assign data_addr_ok = w_addr_ack &  w_sel_data;
  assign inst_data_ok = w_data_ack & ~w_sel_data;
  assign data_data_ok = w_data_ack &  w_sel_data;

  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

endmodule
`default_nettype wire

// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter
// Brief    : Shares one sram-like master port between inst and data sides.
//            ARB_ROUND_ROBIN_EN selects alternating grants under contention.
// Revision : 1.0 - initial release
// ============================================================================
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_like_arbiter_if.slave   inst,
  sram_like_arbiter_if.slave   data,
  sram_like_arbiter_if.master  bus
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic       r_owner;
  logic       w_owner_nxt;
  logic       w_pick;
  logic       w_addr_phase;
  logic       w_data_phase;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_owner;
  logic w_grant;

  assign w_grant = (r_state == ST_IDLE) & (inst.req | data.req);
  // Under contention the side that did not win last time goes next.
  assign w_pick  = (inst.req & data.req) ? ~r_last_owner : data.req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_owner <= OWN_INST;
    end else if (w_grant) begin
      r_last_owner <= w_pick;
    end
  end
`else
  assign w_pick = data.req ? OWN_DATA : OWN_INST;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_INST;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      ST_IDLE: begin
        if (inst.req | data.req) begin
          w_owner_nxt = w_pick;
          w_state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus.addr_ok) begin
          w_state_nxt = bus.data_ok ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.data_ok) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_addr_phase = (r_state == ST_ADDR);
  assign w_data_phase = (r_state == ST_DATA);

  // Registered-only path: no requester input reaches bus.req.
  assign bus.req = w_addr_phase;

  sram_like_req_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_req_mux (
    .owner        (r_owner),
    .addr_phase   (w_addr_phase),
    .data_phase   (w_data_phase),
    .inst_wr      (inst.wr),
    .inst_size    (inst.size),
    .inst_addr    (inst.addr),
    .inst_wdata   (inst.wdata),
    .data_wr      (data.wr),
    .data_size    (data.size),
    .data_addr    (data.addr),
    .data_wdata   (data.wdata),
    .bus_addr_ok  (bus.addr_ok),
    .bus_data_ok  (bus.data_ok),
    .bus_rdata    (bus.rdata),
    .bus_wr       (bus.wr),
    .bus_size     (bus.size),
    .bus_addr     (bus.addr),
    .bus_wdata    (bus.wdata),
    .inst_addr_ok (inst.addr_ok),
    .inst_data_ok (inst.data_ok),
    .inst_rdata   (inst.rdata),
    .data_addr_ok (data.addr_ok),
    .data_data_ok (data.data_ok),
    .data_rdata   (data.rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_like_arbiter
// Brief    : Scoreboard bench; a slave model answers bus transfers in order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  typedef struct {
    logic        owner;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   hold_reqs = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
  sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
  sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .inst (inst_if),
    .data (data_if),
    .bus  (bus_if)
  );

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_txn(input logic owner, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.owner = owner; t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata;
    exp_q.push_back(t);
  endtask

  // Slave model: waits for req, holds addr_ok low addr_lat cycles, then
  // answers; data_lat DATA-state cycles precede data_ok unless same is set.
  task automatic serve(input int addr_lat, input int data_lat, input bit same,
                       input logic [31:0] rd, output int waited);
    txn_t        e;
    logic [67:0] exp_bus;
    logic [1:0]  exp_ok;
    logic [31:0] own_rdata;
    waited = 0;
    @(negedge clk);
    while (bus_if.req !== 1'b1 && waited < 20) begin
      next_cyc();
      @(negedge clk);
      waited++;
    end
    checks++;
    if (bus_if.req !== 1'b1) begin
      failures++;
      $display("FAIL bus_req_timeout req=%b required=1", bus_if.req);
      return;
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_txn addr=%h required=no transfer", bus_if.addr);
      return;
    end
    e       = exp_q.pop_front();
    exp_bus = {1'b1, e.wr, e.size, e.addr, e.wdata};
    exp_ok  = e.owner ? 2'b10 : 2'b01;
    for (int i = 0; i < addr_lat; i++) begin
      if (i > 0) begin
        next_cyc();
        @(negedge clk);
      end
      checks++;
      if ({bus_if.req, bus_if.wr, bus_if.size, bus_if.addr, bus_if.wdata} !== exp_bus ||
          {data_if.addr_ok, inst_if.addr_ok} !== 2'b00) begin
        failures++;
        $display("FAIL addr_wait cyc=%0d bus=%h required=%h addr_oks=%b required=00", i,
                 {bus_if.req, bus_if.wr, bus_if.size, bus_if.addr, bus_if.wdata}, exp_bus,
                 {data_if.addr_ok, inst_if.addr_ok});
      end
    end
    next_cyc();
    bus_if.addr_ok = 1'b1;
    bus_if.data_ok = same;
    bus_if.rdata   = rd;
    @(negedge clk);
    checks++;
    if ({bus_if.req, bus_if.wr, bus_if.size, bus_if.addr, bus_if.wdata} !== exp_bus ||
        {data_if.addr_ok, inst_if.addr_ok} !== exp_ok) begin
      failures++;
      $display("FAIL addr_accept bus=%h required=%h addr_oks=%b required=%b",
               {bus_if.req, bus_if.wr, bus_if.size, bus_if.addr, bus_if.wdata}, exp_bus,
               {data_if.addr_ok, inst_if.addr_ok}, exp_ok);
    end
    own_rdata = e.owner ? data_if.rdata : inst_if.rdata;
    checks++;
    if ({data_if.data_ok, inst_if.data_ok} !== (same ? exp_ok : 2'b00) ||
        (same && own_rdata !== rd)) begin
      failures++;
      $display("FAIL addr_phase_data_ok data_oks=%b required=%b rdata=%h required=%h",
               {data_if.data_ok, inst_if.data_ok}, (same ? exp_ok : 2'b00), own_rdata, rd);
    end
    next_cyc();
    bus_if.addr_ok = 1'b0;
    bus_if.data_ok = 1'b0;
    if (!hold_reqs) begin
      if (e.owner) data_if.req = 1'b0;
      else         inst_if.req = 1'b0;
    end
    if (!same) begin
      for (int i = 0; i < data_lat; i++) begin
        @(negedge clk);
        checks++;
        if ({bus_if.req, data_if.addr_ok, inst_if.addr_ok, data_if.data_ok, inst_if.data_ok} !== 5'b0) begin
          failures++;
          $display("FAIL data_wait cyc=%0d req_aok_dok=%b required=00000", i,
                   {bus_if.req, data_if.addr_ok, inst_if.addr_ok, data_if.data_ok, inst_if.data_ok});
        end
        next_cyc();
      end
      bus_if.data_ok = 1'b1;
      bus_if.rdata   = rd;
      @(negedge clk);
      own_rdata = e.owner ? data_if.rdata : inst_if.rdata;
      checks++;
      if ({data_if.data_ok, inst_if.data_ok} !== exp_ok || own_rdata !== rd ||
          {bus_if.req, data_if.addr_ok, inst_if.addr_ok} !== 3'b000) begin
        failures++;
        $display("FAIL data_return data_oks=%b required=%b rdata=%h required=%h req_aok=%b",
                 {data_if.data_ok, inst_if.data_ok}, exp_ok, own_rdata, rd,
                 {bus_if.req, data_if.addr_ok, inst_if.addr_ok});
      end
      next_cyc();
      bus_if.data_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inst_if.req = 1'b1;
    data_if.req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_cyc();
      @(negedge clk);
      checks++;
      if ({bus_if.req, inst_if.addr_ok, inst_if.data_ok, data_if.addr_ok, data_if.data_ok} !== 5'b0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d req_oks=%b required=00000", i,
                 {bus_if.req, inst_if.addr_ok, inst_if.data_ok, data_if.addr_ok, data_if.data_ok});
      end
    end
    next_cyc();
    inst_if.req = 1'b0;
    data_if.req = 1'b0;
    rst = 1'b0;
    next_cyc();
  endtask

  task automatic test_inst_read();
    int w;
    inst_if.req  = 1'b1;
    inst_if.wr   = 1'b0;
    inst_if.size = SZ_WORD;
    inst_if.addr = 32'hBFC0_0000;
    push_txn(OWN_INST, 1'b0, SZ_WORD, 32'hBFC0_0000, inst_if.wdata);
    serve(1, 1, 1'b0, 32'h3C1D_0001, w);
    checks++;
    if (w !== 1) begin
      failures++;
      $display("FAIL inst_req_latency cycles=%0d required=1", w);
    end
  endtask

  task automatic test_simultaneous();
    int w;
    inst_if.req   = 1'b1;
    inst_if.addr  = 32'hBFC0_0004;
    data_if.req   = 1'b1;
    data_if.wr    = 1'b1;
    data_if.size  = SZ_WORD;
    data_if.addr  = 32'h8000_1000;
    data_if.wdata = 32'hDEAD_BEEF;
    push_txn(OWN_DATA, 1'b1, SZ_WORD, 32'h8000_1000, 32'hDEAD_BEEF);
    push_txn(OWN_INST, 1'b0, SZ_WORD, 32'hBFC0_0004, inst_if.wdata);
    serve(1, 2, 1'b0, 32'h0000_0000, w);
    serve(1, 1, 1'b0, 32'h2408_0005, w);
    checks++;
    if (w !== 1) begin
      failures++;
      $display("FAIL pending_inst_regrant cycles=%0d required=1", w);
    end
  endtask

  task automatic test_same_cycle();
    int w;
    data_if.req  = 1'b1;
    data_if.wr   = 1'b0;
    data_if.size = SZ_BYTE;
    data_if.addr = 32'h8000_2003;
    push_txn(OWN_DATA, 1'b0, SZ_BYTE, 32'h8000_2003, data_if.wdata);
    serve(2, 0, 1'b1, 32'h0000_0077, w);
    // A DATA-state visit would turn this data_ok into a second completion.
    bus_if.data_ok = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus_if.req, data_if.data_ok, inst_if.data_ok} !== 3'b000) begin
      failures++;
      $display("FAIL same_cycle_no_data_state req_doks=%b required=000",
               {bus_if.req, data_if.data_ok, inst_if.data_ok});
    end
    next_cyc();
    bus_if.data_ok = 1'b0;
  endtask

  task automatic test_stray_and_reset();
    int n;
    bus_if.data_ok = 1'b1;
    bus_if.rdata   = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({bus_if.req, data_if.data_ok, inst_if.data_ok} !== 3'b000) begin
        failures++;
        $display("FAIL stray_data_ok cyc=%0d req_doks=%b required=000", i,
                 {bus_if.req, data_if.data_ok, inst_if.data_ok});
      end
      next_cyc();
    end
    bus_if.data_ok = 1'b0;
    inst_if.req  = 1'b1;
    inst_if.addr = 32'hBFC0_0100;
    n = 0;
    @(negedge clk);
    while (bus_if.req !== 1'b1 && n < 20) begin
      next_cyc();
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus_if.req !== 1'b1) begin
      failures++;
      $display("FAIL rst_txn_req_timeout req=%b required=1", bus_if.req);
    end
    next_cyc();
    bus_if.addr_ok = 1'b1;
    next_cyc();
    bus_if.addr_ok = 1'b0;
    inst_if.req    = 1'b0;
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    bus_if.data_ok = 1'b1;
    bus_if.rdata   = 32'hCAFE_F00D;
    @(negedge clk);
    checks++;
    if ({bus_if.req, data_if.data_ok, inst_if.data_ok} !== 3'b000) begin
      failures++;
      $display("FAIL late_data_ok_after_rst req_doks=%b required=000",
               {bus_if.req, data_if.data_ok, inst_if.data_ok});
    end
    next_cyc();
    bus_if.data_ok = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.req !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_rst req=%b required=0", bus_if.req);
    end
    next_cyc();
  endtask

  task automatic test_backpressure();
    int w;
    data_if.req   = 1'b1;
    data_if.wr    = 1'b1;
    data_if.size  = SZ_HALF;
    data_if.addr  = 32'h8000_2002;
    data_if.wdata = 32'h0000_A5A5;
    push_txn(OWN_DATA, 1'b1, SZ_HALF, 32'h8000_2002, 32'h0000_A5A5);
    serve(5, 2, 1'b0, 32'h0, w);
  endtask

  task automatic test_contended_order();
    int w;
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    hold_reqs     = 1'b1;
    inst_if.req   = 1'b1;
    inst_if.wr    = 1'b0;
    inst_if.size  = SZ_WORD;
    inst_if.addr  = 32'hBFC0_0200;
    data_if.req   = 1'b1;
    data_if.wr    = 1'b0;
    data_if.size  = SZ_WORD;
    data_if.addr  = 32'h8000_3000;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (k % 2 == 0) push_txn(OWN_DATA, 1'b0, SZ_WORD, 32'h8000_3000, data_if.wdata);
      else            push_txn(OWN_INST, 1'b0, SZ_WORD, 32'hBFC0_0200, inst_if.wdata);
`else
      push_txn(OWN_DATA, 1'b0, SZ_WORD, 32'h8000_3000, data_if.wdata);
`endif
    end
    for (int k = 0; k < 4; k++) begin
      serve(1, 1, 1'b0, 32'h1000_0000 + k, w);
    end
    hold_reqs   = 1'b0;
    inst_if.req = 1'b0;
    data_if.req = 1'b0;
    next_cyc();
  endtask

  initial begin
    inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = SZ_WORD;
    inst_if.addr = 32'h0; inst_if.wdata = 32'h0;
    data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = SZ_WORD;
    data_if.addr = 32'h0; data_if.wdata = 32'h0;
    bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0; bus_if.rdata = 32'h0;
    test_reset();
    test_inst_read();
    test_simultaneous();
    test_same_cycle();
    test_stray_and_reset();
    test_backpressure();
    test_contended_order();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required=finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
